// File: rtl/gb_cpu_nibble_alu.sv
// gb_cpu_nibble_alu: nibble-serial ALU for the CPU execute stage.
// Operands are processed 4 bits per cycle through a registered carry chain.
// The result and Z/N/H/C flags are returned through a valid/ready handshake.
// Optional feature macro: GB_CPU_ALU_DAA_EN (adds DAA as op 8 plus the
// daa_n_in/daa_h_in ports). When it is undefined, op 8 is illegal.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | in_ready=1, waiting for a request
// CALC   | one nibble per cycle, LSB first, for NIBBLES cycles
// DONE   | out_valid=1, result/flags held until out_ready

module gb_cpu_nibble_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             carry_in,
`ifdef GB_CPU_ALU_DAA_EN
  input  logic             daa_n_in,
  input  logic             daa_h_in,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_h,
  output logic             flag_c,
  output logic             op_illegal
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = $clog2(NIBBLES);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_ADC = 4'd1;
  localparam logic [3:0] OP_SUB = 4'd2;
  localparam logic [3:0] OP_SBC = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4;
  localparam logic [3:0] OP_XOR = 4'd5;
  localparam logic [3:0] OP_OR  = 4'd6;
  localparam logic [3:0] OP_CP  = 4'd7;
`ifdef GB_CPU_ALU_DAA_EN
  localparam logic [3:0] OP_DAA = 4'd8;
`endif

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t state_q, state_d;

  logic [3:0]       op_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-5:0] acc_q;     // result nibbles collected so far, shifted in from the top
  logic [CW-1:0]    cnt_q;     // nibbles remaining minus one
  logic             carry_q;
  logic             h_q;       // raw carry out of nibble NIBBLES-2
  logic             carry_init;

  logic [CW-1:0]    k_idx;
  logic             is_sub;
  logic [3:0]       a_nib, b_nib, b_add, nib_out;
  logic [4:0]       sum5;
  logic [WIDTH-1:0] full;

  logic [WIDTH-1:0] fin_result;
  logic             fin_z, fin_n, fin_h, fin_c, fin_ill;

`ifdef GB_CPU_ALU_DAA_EN
  logic             cin_q, daa_n_q, daa_h_q;
  logic [7:0]       daa_adj, daa_r8;
  logic [WIDTH-1:0] daa_res;
  logic             daa_c;
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: accept, count nibbles down to terminal count, hand off.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid)            state_d = S_CALC;
      S_CALC: if (cnt_q == '0)         state_d = S_DONE;
      S_DONE: if (out_ready)           state_d = S_IDLE;
      default:                         state_d = S_IDLE;
    endcase
  end

  // Initial carry of the chain: subtraction is a + ~b + cin'.
  always_comb begin
    carry_init = 1'b0;
    case (op)
      OP_ADC:        carry_init = carry_in;
      OP_SUB, OP_CP: carry_init = 1'b1;
      OP_SBC:        carry_init = ~carry_in;
      default:       carry_init = 1'b0;
    endcase
  end

  // One nibble of the carry chain / logic op for the current CALC cycle.
  always_comb begin
    k_idx   = CW'(NIBBLES - 1) - cnt_q;
    is_sub  = (op_q == OP_SUB) || (op_q == OP_SBC) || (op_q == OP_CP);
    a_nib   = 4'(a_q >> {k_idx, 2'b00});
    b_nib   = 4'(b_q >> {k_idx, 2'b00});
    b_add   = is_sub ? ~b_nib : b_nib;
    sum5    = {1'b0, a_nib} + {1'b0, b_add} + {4'b0000, carry_q};
    case (op_q)
      OP_AND:  nib_out = a_nib & b_nib;
      OP_XOR:  nib_out = a_nib ^ b_nib;
      OP_OR:   nib_out = a_nib | b_nib;
      default: nib_out = sum5[3:0];
    endcase
    full = {nib_out, acc_q};
  end

`ifdef GB_CPU_ALU_DAA_EN
  // Decimal adjust of the low byte; upper bits pass through.
  always_comb begin
    daa_adj = 8'h00;
    daa_c   = cin_q;
    daa_r8  = a_q[7:0];
    if (!daa_n_q) begin
      daa_c = 1'b0;
      if (cin_q || (a_q[7:0] > 8'h99)) begin
        daa_adj[7:4] = 4'h6;
        daa_c        = 1'b1;
      end
      if (daa_h_q || (a_q[3:0] > 4'h9)) daa_adj[3:0] = 4'h6;
      daa_r8 = a_q[7:0] + daa_adj;
    end else begin
      if (cin_q)   daa_adj[7:4] = 4'h6;
      if (daa_h_q) daa_adj[3:0] = 4'h6;
      daa_r8 = a_q[7:0] - daa_adj;
    end
    daa_res      = a_q;
    daa_res[7:0] = daa_r8;
  end
`endif

  // Final result and flags, taken on the last CALC cycle.
  always_comb begin
    fin_result = full;
    fin_z      = (full == '0);
    fin_n      = 1'b0;
    fin_h      = 1'b0;
    fin_c      = 1'b0;
    fin_ill    = 1'b0;
    case (op_q)
      OP_ADD, OP_ADC: begin
        fin_h = h_q;
        fin_c = sum5[4];
      end
      OP_SUB, OP_SBC: begin
        fin_n = 1'b1;
        fin_h = ~h_q;
        fin_c = ~sum5[4];
      end
      OP_CP: begin
        fin_result = a_q;
        fin_n      = 1'b1;
        fin_h      = ~h_q;
        fin_c      = ~sum5[4];
      end
      OP_AND: fin_h = 1'b1;
      OP_XOR, OP_OR: ;
`ifdef GB_CPU_ALU_DAA_EN
      OP_DAA: begin
        fin_result = daa_res;
        fin_z      = (daa_res == '0);
        fin_n      = daa_n_q;
        fin_c      = daa_c;
      end
`endif
      default: begin
        fin_result = a_q;
        fin_z      = 1'b0;
        fin_ill    = 1'b1;
      end
    endcase
  end

  // Operand latch, nibble chain registers and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      carry_q    <= 1'b0;
      h_q        <= 1'b0;
      result     <= '0;
      flag_z     <= 1'b0;
      flag_n     <= 1'b0;
      flag_h     <= 1'b0;
      flag_c     <= 1'b0;
      op_illegal <= 1'b0;
`ifdef GB_CPU_ALU_DAA_EN
      cin_q      <= 1'b0;
      daa_n_q    <= 1'b0;
      daa_h_q    <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) begin
          op_q    <= op;
          a_q     <= operand_a;
          b_q     <= operand_b;
          cnt_q   <= CW'(NIBBLES - 1);
          carry_q <= carry_init;
          h_q     <= 1'b0;
`ifdef GB_CPU_ALU_DAA_EN
          cin_q   <= carry_in;
          daa_n_q <= daa_n_in;
          daa_h_q <= daa_h_in;
`endif
        end
        S_CALC: begin
          acc_q   <= (WIDTH-4)'(full >> 4);
          carry_q <= sum5[4];
          if (cnt_q == CW'(1)) h_q <= sum5[4];
          if (cnt_q == '0) begin
            result     <= fin_result;
            flag_z     <= fin_z;
            flag_n     <= fin_n;
            flag_h     <= fin_h;
            flag_c     <= fin_c;
            op_illegal <= fin_ill;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_cpu_nibble_alu.sv
// Directed bench for gb_cpu_nibble_alu: an 8-bit and a 16-bit instance.
module tb_gb_cpu_nibble_alu;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_valid16, out_ready, carry_in;
  logic [3:0]  op;
  logic [7:0]  a, b;
  logic [15:0] a16, b16;
  logic        in_ready, out_valid, z, n, h, c, ill;
  logic [7:0]  res;
  logic        in_ready16, out_valid16, z16, n16, h16, c16, ill16;
  logic [15:0] res16;
`ifdef GB_CPU_ALU_DAA_EN
  logic        daa_n, daa_h;
`endif

  int n_checks = 0;
  int n_err    = 0;
  int lat;

  always #5 clk = ~clk;

  gb_cpu_nibble_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .operand_a(a), .operand_b(b), .carry_in(carry_in),
`ifdef GB_CPU_ALU_DAA_EN
    .daa_n_in(daa_n), .daa_h_in(daa_h),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .result(res),
    .flag_z(z), .flag_n(n), .flag_h(h), .flag_c(c), .op_illegal(ill)
  );

  gb_cpu_nibble_alu #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
    .op(op), .operand_a(a16), .operand_b(b16), .carry_in(carry_in),
`ifdef GB_CPU_ALU_DAA_EN
    .daa_n_in(daa_n), .daa_h_in(daa_h),
`endif
    .out_valid(out_valid16), .out_ready(out_ready), .result(res16),
    .flag_z(z16), .flag_n(n16), .flag_h(h16), .flag_c(c16), .op_illegal(ill16)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 8-bit unit, scramble inputs after accept, measure latency.
  task automatic run8(input logic [3:0] o, input logic [7:0] xa, input logic [7:0] xb,
                      input logic ci, output int l);
    op = o; a = xa; b = xb; carry_in = ci; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; op = 4'hF; a = ~xa; b = ~xb; carry_in = ~ci;
    l = 0;
    while (!out_valid && l < 20) begin
      @(posedge clk); #1;
      l++;
    end
  endtask

  task automatic finish8;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", {31'b0, in_ready}, 32'd1);
  endtask

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_valid16 = 1'b0; out_ready = 1'b0;
    carry_in = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00; a16 = 16'h0; b16 = 16'h0;
`ifdef GB_CPU_ALU_DAA_EN
    daa_n = 1'b0; daa_h = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rst_result",    {24'b0, res},       32'h00);
    chk("rst_flags",     {27'b0, z, n, h, c, ill}, 32'd0);
    reset = 1'b0;

    // T1 ADD
    run8(4'd0, 8'h3A, 8'hC6, 1'b0, lat);
    chk("add_lat",    lat, 32'd2);
    chk("add_result", {24'b0, res}, 32'h00);
    chk("add_flags",  {28'b0, z, n, h, c}, 32'b1011);
    chk("add_ill",    {31'b0, ill}, 32'd0);
    chk("done_in_ready", {31'b0, in_ready}, 32'd0);
    finish8();

    // T2 SUB and CP
    run8(4'd2, 8'h3E, 8'h3F, 1'b0, lat);
    chk("sub_result", {24'b0, res}, 32'hFF);
    chk("sub_flags",  {28'b0, z, n, h, c}, 32'b0111);
    finish8();
    run8(4'd7, 8'h3E, 8'h3F, 1'b0, lat);
    chk("cp_result", {24'b0, res}, 32'h3E);
    chk("cp_flags",  {28'b0, z, n, h, c}, 32'b0111);
    finish8();

    // T3 ADC and logic ops
    run8(4'd1, 8'hE1, 8'h0F, 1'b1, lat);
    chk("adc_result", {24'b0, res}, 32'hF1);
    chk("adc_flags",  {28'b0, z, n, h, c}, 32'b0010);
    finish8();
    run8(4'd4, 8'hF0, 8'h0F, 1'b1, lat);
    chk("and_lat",    lat, 32'd2);
    chk("and_result", {24'b0, res}, 32'h00);
    chk("and_flags",  {28'b0, z, n, h, c}, 32'b1010);
    finish8();
    run8(4'd5, 8'h5A, 8'hFF, 1'b1, lat);
    chk("xor_result", {24'b0, res}, 32'hA5);
    chk("xor_flags",  {28'b0, z, n, h, c}, 32'b0000);
    finish8();
    run8(4'd6, 8'h00, 8'h00, 1'b1, lat);
    chk("or_result", {24'b0, res}, 32'h00);
    chk("or_flags",  {28'b0, z, n, h, c}, 32'b1000);
    finish8();

    // SBC: 0x10 - 0x01 - 1 = 0x0E, half borrow only
    run8(4'd3, 8'h10, 8'h01, 1'b1, lat);
    chk("sbc_result", {24'b0, res}, 32'h0E);
    chk("sbc_flags",  {28'b0, z, n, h, c}, 32'b0110);
    finish8();

    // Illegal op
    run8(4'd9, 8'h42, 8'h11, 1'b1, lat);
    chk("ill_lat",    lat, 32'd2);
    chk("ill_result", {24'b0, res}, 32'h42);
    chk("ill_flags",  {28'b0, z, n, h, c}, 32'b0000);
    chk("ill_flag",   {31'b0, ill}, 32'd1);
    finish8();

    // T6 op 8
    run8(4'd8, 8'h7D, 8'h00, 1'b0, lat);
    chk("op8_lat", lat, 32'd2);
`ifdef GB_CPU_ALU_DAA_EN
    chk("daa_result", {24'b0, res}, 32'h83);
    chk("daa_flags",  {28'b0, z, n, h, c}, 32'b0000);
    chk("daa_ill",    {31'b0, ill}, 32'd0);
`else
    chk("op8_result", {24'b0, res}, 32'h7D);
    chk("op8_ill",    {31'b0, ill}, 32'd1);
`endif
    finish8();

    // T5 backpressure: 0x12 + 0x34 = 0x46
    run8(4'd0, 8'h12, 8'h34, 1'b0, lat);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid",    {31'b0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, in_ready},  32'd0);
      chk("bp_result",   {24'b0, res},       32'h46);
      chk("bp_flags",    {28'b0, z, n, h, c}, 32'b0000);
      @(posedge clk); #1;
    end
    finish8();

    // Reset mid-CALC
    op = 4'd0; a = 8'h01; b = 8'h02; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rstc_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rstc_in_ready",  {31'b0, in_ready},  32'd1);
    chk("rstc_result",    {24'b0, res},       32'h00);
    repeat (3) @(posedge clk);
    #1;
    chk("rstc_no_valid", {31'b0, out_valid}, 32'd0);

    // T4 WIDTH=16 ADD
    op = 4'd0; a16 = 16'h0FFF; b16 = 16'h0001; carry_in = 1'b1; in_valid16 = 1'b1;
    @(posedge clk); #1;
    in_valid16 = 1'b0; a16 = 16'hAAAA; b16 = 16'h5555;
    lat = 0;
    while (!out_valid16 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("add16_lat",    lat, 32'd4);
    chk("add16_result", {16'b0, res16}, 32'h1000);
    chk("add16_flags",  {27'b0, z16, n16, h16, c16, ill16}, 32'b00100);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("add16_in_ready", {31'b0, in_ready16}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
